oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite-attribute DMA engine sitting directly upstream of the PPU's sprite table at FE00-FE9F.
- A CPU write to FF46 with value XX starts a copy of 160 bytes from XX00-XX9F into OAM, one byte per BYTE_CYCLES clocks.
- Reads come from the system bus through a dedicated master port; writes go out through a dedicated OAM write port that the PPU merges with its CPU-side OAM store path.
- busy tells the bus arbiter / PPU that a transfer is in flight.

Parameters:
- OAM_BYTES, 160, number of bytes copied per transfer (OAM size)
- BYTE_CYCLES, 4, clocks per transferred byte; must be >= 3
- REG_ADDR, 16'hFF46, CPU-visible DMA source register address

Ports:
- clockgb  in  1  system (Game Boy) clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- address  in  16  CPU bus address
- indata  in  8  CPU write data
- outdata  out  8  CPU read data; 0 unless a load hits REG_ADDR (OR-bus convention)
- load  in  1  CPU read strobe
- store  in  1  CPU write strobe
- dma_address  out  16  source address for the DMA read
- dma_load  out  1  one-cycle read request
- dma_indata  in  8  read data, valid the cycle after dma_load
- oam_address  out  8  OAM byte index, 0..OAM_BYTES-1
- oam_data  out  8  byte to write into OAM
- oam_store  out  1  one-cycle OAM write pulse
- busy  out  1  transfer in progress

Behaviour:
- Clock and reset: single clock clockgb; reset synchronous, active-high.
- Reset values: busy=0, dma_load=0, dma_address=0, oam_store=0, oam_address=0, oam_data=0, outdata=0, source register=8'hFF, state IDLE.
- CPU register:
  - store with address==REG_ADDR latches indata into src.
  - load with address==REG_ADDR returns src on outdata the next cycle (registered); otherwise outdata=0.
- Source mapping: effective page = src if src<8'hE0, else src-8'h20 (E0-FF mirror C0-DF).
- States: IDLE, (START), XFER.
- IDLE: on REG_ADDR store -> XFER (or START under the optional feature); byte index=0, phase=0; busy=1 from the next cycle.
- XFER, per byte at index i, phase p counting 0..BYTE_CYCLES-1:
  - p=0: dma_load=1, dma_address={page,i}.
  - p=1: capture dma_indata into oam_data.
  - p=2: oam_store=1, oam_address=i.
  - Other phases idle.
  - At p=BYTE_CYCLES-1: if i==OAM_BYTES-1 -> IDLE and busy=0 next cycle; else i+1, p=0.
- Duration: busy high exactly OAM_BYTES*BYTE_CYCLES cycles (640 by default).
- Restart: a REG_ADDR store while busy updates src and restarts at i=0, p=0 from the new page on the next cycle. Any half-finished byte is abandoned; no oam_store is issued for it. busy stays high without a gap.
- Store and final phase in the same cycle: the restart wins.
- Reset mid-transfer: abort immediately to reset values; no further dma_load or oam_store.
- CPU accesses to OAM during busy are not blocked here; the PPU/arbiter gates them using busy.
- dma_load and oam_store never assert in the same cycle.

Optional Feature:
- Macro OAM_DMA_STARTUP_EN.
- Defined: an extra START state of BYTE_CYCLES cycles (busy=1, no bus activity) precedes the first byte; busy lasts (OAM_BYTES+1)*BYTE_CYCLES cycles (644). A restart also passes through START.
- Undefined: START is absent and the first dma_load issues the cycle after the trigger.

Decomposition:
- Shared package gb_ppu_pkg:
  - constants OAM_BASE=16'hFE00, DMA_REG=16'hFF46, OAM_BYTES=160, ECHO_BASE=8'hE0;
  - dma_state_t enum {IDLE, START, XFER}.
- One natural sub-module, oam_dma_timer: byte index and phase counters with restart/clear inputs, emitting phase strobes and a last-byte flag.

Test Plan:
- Write 8'hC1 to FF46; memory model holds C100+i = i^8'h5A -> 160 oam_store pulses, oam_address 0..159, data i^8'h5A; busy high exactly 640 cycles; first dma_address 16'hC100, last 16'hC19F.
- Write 8'hE3 -> dma_address sequence starts at 16'hC300 (echo mapping); FF46 readback returns 8'hE3.
- Write 8'hC0, then 8'hD0 after 50 cycles -> no oam_store at the abandoned index; sequence restarts at oam_address 0 from D000; busy contiguous, 690 cycles total.
- Assert reset at cycle 300 of a transfer -> same cycle + 1: busy=0, no further dma_load/oam_store; FF46 reads 8'hFF.
- With OAM_DMA_STARTUP_EN: write 8'h80 -> first dma_load 5 cycles after the store; busy 644 cycles.
- Load from addresses other than FF46 during a transfer -> outdata=0; dma_load and oam_store never overlap (assertion).

Source files
------------

// File: rtl/gb_ppu_pkg.sv
// Shared PPU-side constants, DMA state encoding and the echo-RAM source page mapping.
package gb_ppu_pkg;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam int          OAM_BYTES = 160;
  localparam logic [7:0]  ECHO_BASE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  // E0-FF mirror C0-DF, so those source pages are pulled down by 0x20.
  function automatic logic [7:0] dma_page(input logic [7:0] src);
    return (src < ECHO_BASE) ? src : (src - 8'h20);
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU register port, system-bus read port and OAM write port of the OAM DMA engine.
interface oam_dma_if;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic [15:0] dma_address;
  logic        dma_load;
  logic [7:0]  dma_indata;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;
  logic        oam_store;
  logic        busy;

  modport master (
    input  address, indata, load, store, dma_indata,
    output outdata, dma_address, dma_load, oam_address, oam_data, oam_store, busy
  );

  modport slave (
    output address, indata, load, store, dma_indata,
    input  outdata, dma_address, dma_load, oam_address, oam_data, oam_store, busy
  );
endinterface

// File: rtl/oam_dma_timer.sv
// Byte index and per-byte phase counters; clear returns both to zero and wins over run.
module oam_dma_timer #(
  parameter int OAM_BYTES   = 160,
  parameter int BYTE_CYCLES = 4
) (
  input  logic       clockgb,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  output logic [7:0] idx,
  output logic       capture,
  output logic       phase_end,
  output logic       last_byte
);
  localparam int            PW     = $clog2(BYTE_CYCLES);
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(BYTE_CYCLES - 1);
  localparam logic [7:0]    I_LAST = 8'(OAM_BYTES - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clockgb) begin
    if (reset || clear) begin
      idx   <= 8'h00;
      phase <= '0;
    end else if (run) begin
      if (phase == P_LAST) begin
        phase <= '0;
        idx   <= idx + 8'd1;
      end else begin
        phase <= phase + ONE;
      end
    end
  end

  // Read data is valid during phase 1, so the OAM write goes out in phase 2.
  assign capture   = (phase == ONE);
  assign phase_end = (phase == P_LAST);
  assign last_byte = (idx == I_LAST);
endmodule

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to REG_ADDR copies page {src,00..9F} into OAM, one byte per BYTE_CYCLES clocks.
// Define OAM_DMA_STARTUP_EN to insert a BYTE_CYCLES-long START state ahead of the first byte.
module oam_dma #(
  parameter int          OAM_BYTES   = gb_ppu_pkg::OAM_BYTES,
  parameter int          BYTE_CYCLES = 4,
  parameter logic [15:0] REG_ADDR    = gb_ppu_pkg::DMA_REG
) (
  input logic       clockgb,
  input logic       reset,
  oam_dma_if.master bus
);
  import gb_ppu_pkg::*;

  dma_state_t  state;
  logic [7:0]  src;
  logic        busy_q;
  logic        dma_load_q;
  logic [15:0] dma_address_q;
  logic        oam_store_q;
  logic [7:0]  oam_address_q;
  logic [7:0]  oam_data_q;
  logic [7:0]  outdata_q;

  logic [7:0] idx;
  logic       capture;
  logic       phase_end;
  logic       last_byte;
  logic       reg_wr;
  logic       reg_rd;
  logic       t_clear;

  assign reg_wr = bus.store && (bus.address == REG_ADDR);
  assign reg_rd = bus.load  && (bus.address == REG_ADDR);

  // A register write restarts the counters even mid-transfer, abandoning the current byte.
  assign t_clear = reg_wr
                 || ((state == START) && phase_end)
                 || ((state == XFER) && phase_end && last_byte);

  oam_dma_timer #(
    .OAM_BYTES  (OAM_BYTES),
    .BYTE_CYCLES(BYTE_CYCLES)
  ) u_timer (
    .clockgb  (clockgb),
    .reset    (reset),
    .clear    (t_clear),
    .run      (state != IDLE),
    .idx      (idx),
    .capture  (capture),
    .phase_end(phase_end),
    .last_byte(last_byte)
  );

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state         <= IDLE;
      src           <= 8'hFF;
      busy_q        <= 1'b0;
      dma_load_q    <= 1'b0;
      dma_address_q <= 16'h0000;
      oam_store_q   <= 1'b0;
      oam_address_q <= 8'h00;
      oam_data_q    <= 8'h00;
      outdata_q     <= 8'h00;
    end else begin
      dma_load_q  <= 1'b0;
      oam_store_q <= 1'b0;
      outdata_q   <= reg_rd ? src : 8'h00;
      if (reg_wr) begin
        src    <= bus.indata;
        busy_q <= 1'b1;
`ifdef OAM_DMA_STARTUP_EN
        state  <= START;
`else
        state         <= XFER;
        dma_load_q    <= 1'b1;
        dma_address_q <= {dma_page(bus.indata), 8'h00};
`endif
      end else begin
        case (state)
          START: begin
            if (phase_end) begin
              state         <= XFER;
              dma_load_q    <= 1'b1;
              dma_address_q <= {dma_page(src), 8'h00};
            end
          end
          XFER: begin
            if (capture) begin
              oam_data_q    <= bus.dma_indata;
              oam_store_q   <= 1'b1;
              oam_address_q <= idx;
            end
            if (phase_end) begin
              if (last_byte) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                dma_load_q    <= 1'b1;
                dma_address_q <= {dma_page(src), idx + 8'd1};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.outdata     = outdata_q;
  assign bus.dma_address = dma_address_q;
  assign bus.dma_load    = dma_load_q;
  assign bus.oam_address = oam_address_q;
  assign bus.oam_data    = oam_data_q;
  assign bus.oam_store   = oam_store_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes cycle-stamped expected events, a monitor pops and compares.
module tb_oam_dma;
  import gb_ppu_pkg::*;

  localparam int BC = 4;
`ifdef OAM_DMA_STARTUP_EN
  localparam int OFF = BC;
`else
  localparam int OFF = 0;
`endif
  localparam int TOTAL = OAM_BYTES * BC + OFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  oam_dma_if bif();

  oam_dma #(.OAM_BYTES(OAM_BYTES), .BYTE_CYCLES(BC), .REG_ADDR(DMA_REG)) dut (
    .clockgb(clk),
    .reset  (reset),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t q_load[$];
  ev_t q_store[$];
  ev_t q_rd[$];
  int  q_len[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] m_src = 8'hFF;
  int win_start = 1;
  int win_end = 0;
  int cur_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  function automatic logic [15:0] src_addr(input logic [7:0] v, input int i);
    int p;
    p = int'(v);
    if (p >= 224) p = p - 32;
    return 16'(p * 256 + i);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drop_after(input int n);
    while (q_load.size() > 0 && q_load[$].cyc > n) q_load.pop_back();
    while (q_store.size() > 0 && q_store[$].cyc > n) q_store.pop_back();
    while (q_rd.size() > 0 && q_rd[$].cyc > n) q_rd.pop_back();
  endtask

  task automatic cpu_store(input logic [7:0] v);
    int n;
    logic [15:0] a;
    n = cyc;
    bif.address = DMA_REG;
    bif.indata  = v;
    bif.store   = 1'b1;
    if (n >= win_start && n <= win_end) begin
      drop_after(n);
      q_len[$] = n - cur_start + 1 + TOTAL;
    end else begin
      cur_start = n + 1;
      win_start = n + 1;
      q_len.push_back(TOTAL);
    end
    win_end = n + TOTAL;
    m_src = v;
    for (int i = 0; i < OAM_BYTES; i++) begin
      a = src_addr(v, i);
      q_load.push_back('{n + 1 + OFF + BC * i, a, 8'h00});
      q_store.push_back('{n + 3 + OFF + BC * i, OAM_BASE + 16'(i), mem(a)});
    end
    tick();
    bif.store = 1'b0;
  endtask

  task automatic cpu_load(input logic [15:0] a);
    bif.address = a;
    bif.load    = 1'b1;
    q_rd.push_back('{cyc + 1, a, (a == DMA_REG) ? m_src : 8'h00});
    tick();
    bif.load = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    n = cyc;
    reset = 1'b1;
    drop_after(n);
    if (win_end > n) begin
      win_end = n;
      q_len[$] = n - cur_start + 1;
    end
    m_src = 8'hFF;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 3) == 0) a = DMA_REG;
    return a;
  endfunction

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 15) == 0) cpu_load(rand_addr());
      else tick();
    end
  endtask

  task automatic run_until_idle();
    int lim;
    lim = 5000;
    while (cyc <= win_end + 2 && lim > 0) begin
      tick();
      lim--;
    end
    chk("idle after transfer", int'(bif.busy), 0);
  endtask

  // Memory model: data for a dma_load appears during the following cycle, garbage otherwise.
  initial begin
    logic        pl;
    logic [15:0] pa;
    pl = 1'b0;
    pa = 16'h0000;
    bif.dma_indata = 8'h00;
    forever begin
      @(negedge clk);
      bif.dma_indata = pl ? mem(pa) : 8'($urandom);
      pl = bif.dma_load;
      pa = bif.dma_address;
    end
  end

  // Monitor
  initial begin
    int run;
    logic [7:0] exp_o;
    run = 0;
    forever begin
      @(negedge clk);
      chk("busy", int'(bif.busy), int'(cyc >= win_start && cyc <= win_end));
      exp_o = 8'h00;
      if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
        exp_o = q_rd[0].d;
        q_rd.delete(0);
      end
      chk("outdata", int'(bif.outdata), int'(exp_o));
      chk("dma_load/oam_store overlap", int'(bif.dma_load & bif.oam_store), 0);
      while (q_load.size() > 0 && q_load[0].cyc < cyc) begin
        chk("dma_load missing at cycle", cyc, q_load[0].cyc);
        q_load.delete(0);
      end
      while (q_store.size() > 0 && q_store[0].cyc < cyc) begin
        chk("oam_store missing at cycle", cyc, q_store[0].cyc);
        q_store.delete(0);
      end
      if (bif.dma_load) begin
        if (q_load.size() == 0) chk("dma_load unexpected", int'(bif.dma_load), 0);
        else if (q_load[0].cyc != cyc) chk("dma_load early", cyc, q_load[0].cyc);
        else begin
          chk("dma_address", int'(bif.dma_address), int'(q_load[0].a));
          q_load.delete(0);
        end
      end
      if (bif.oam_store) begin
        if (q_store.size() == 0) chk("oam_store unexpected", int'(bif.oam_store), 0);
        else if (q_store[0].cyc != cyc) chk("oam_store early", cyc, q_store[0].cyc);
        else begin
          chk("oam_address", int'(OAM_BASE + 16'(bif.oam_address)), int'(q_store[0].a));
          chk("oam_data", int'(bif.oam_data), int'(q_store[0].d));
          q_store.delete(0);
        end
      end
      if (bif.busy) run++;
      else if (run > 0) begin
        if (q_len.size() > 0) begin
          chk("busy length", run, q_len[0]);
          q_len.delete(0);
        end else begin
          chk("busy length unexpected run", run, 0);
        end
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [7:0] v;
    bif.address = 16'h0000;
    bif.indata  = 8'h00;
    bif.load    = 1'b0;
    bif.store   = 1'b0;
    repeat (3) tick();
    chk("reset busy", int'(bif.busy), 0);
    chk("reset dma_load", int'(bif.dma_load), 0);
    chk("reset dma_address", int'(bif.dma_address), 0);
    chk("reset oam_store", int'(bif.oam_store), 0);
    chk("reset oam_address", int'(bif.oam_address), 0);
    chk("reset oam_data", int'(bif.oam_data), 0);
    chk("reset outdata", int'(bif.outdata), 0);
    reset = 1'b0;
    tick();
    cpu_load(DMA_REG);
    tick();

    // Plain page C1: i ^ 5A into OAM 0..159
    cpu_store(8'hC1);
    run_until_idle();

    // Echo page E3 maps to C3; readback returns the raw register value
    cpu_store(8'hE3);
    repeat (20) tick();
    cpu_load(DMA_REG);
    cpu_load(OAM_BASE);
    cpu_load(16'hFF45);
    run_cycles(100);
    run_until_idle();

    // Restart 50 cycles in
    cpu_store(8'hC0);
    repeat (49) tick();
    cpu_store(8'hD0);
    run_until_idle();

    // Restart landing on the final phase of the final byte
    cpu_store(8'hFF);
    repeat (TOTAL - 1) tick();
    cpu_store(8'hE0);
    run_until_idle();

    // Reset 300 cycles into a transfer
    cpu_store(8'hDF);
    repeat (299) tick();
    do_reset();
    repeat (5) tick();
    cpu_load(DMA_REG);
    repeat (20) tick();

    // Random pages with optional random restarts and background CPU loads
    for (int t = 0; t < 5; t++) begin
      v = 8'($urandom);
      cpu_store(v);
      if ($urandom_range(0, 1) == 1) begin
        run_cycles($urandom_range(1, TOTAL + 20));
        cpu_store(8'($urandom));
      end
      run_cycles(50);
      run_until_idle();
    end

    repeat (10) tick();
    chk("pending dma_load entries", q_load.size(), 0);
    chk("pending oam_store entries", q_store.size(), 0);
    chk("pending busy runs", q_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
